// File: rtl/stream_extremum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_extremum_pkg
// Purpose  : Shared types and constants for the streaming extremum reducer.
//            FSM state encoding, mode encoding and an index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package stream_extremum_pkg;

  // Frame reduction FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Mode encoding: 0 selects maximum, 1 selects minimum
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Width of a 0-based position inside a frame, never narrower than 1 bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : stream_extremum_pkg
`default_nettype wire

// File: rtl/stream_extremum_extremum_sel.sv
`default_nettype none
// ============================================================================
// Module   : extremum_sel
// Purpose  : Combinational two-input max/min select. The current value is
//            kept on a tie; take_new flags that the candidate wins.
// Revision : 1.0 - initial release
// ============================================================================
module extremum_sel
  import stream_extremum_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] cand,
  input  logic              mode,
  output logic [DATA_W-1:0] next_val,
  output logic              take_new
);

  // Strict comparison so that a tie keeps the earlier (current) value
  always_comb begin
    take_new = (mode == MODE_MAX) ? (cand > cur) : (cand < cur);
    next_val = take_new ? cand : cur;
  end

endmodule : extremum_sel
`default_nettype wire

// File: rtl/stream_extremum.sv
`default_nettype none
// ============================================================================
// Module   : stream_extremum
// Purpose  : Reduces each frame of FRAME_LEN unsigned samples from a
//            valid/ready stream to its maximum (mode=0) or minimum (mode=1)
//            and presents the result on a valid/ready output.
//            Optional macro STREAM_EXTREMUM_INDEX_EN adds out_idx, the
//            0-based position of the extremum within the frame.
// Revision : 1.0 - initial release
// ============================================================================
module stream_extremum
  import stream_extremum_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int FRAME_LEN = 4,
  parameter  int CNT_W     = $clog2(FRAME_LEN + 1),
  localparam int IDX_W     = idx_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef STREAM_EXTREMUM_INDEX_EN
  output logic [IDX_W-1:0]  out_idx,
`endif
  output logic              out_mode
);

  // Counter value seen while the final sample of a frame is being accepted
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic              frame_mode;
  logic [DATA_W-1:0] sel_val;
  logic              take_new;

  extremum_sel #(
    .DATA_W (DATA_W)
  ) u_sel (
    .cur      (acc),
    .cand     (in_data),
    .mode     (frame_mode),
    .next_val (sel_val),
    .take_new (take_new)
  );

  // Input is blocked only while a result waits for its consumer
  assign in_ready = (state != HOLD);

`ifdef STREAM_EXTREMUM_INDEX_EN
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] cnt_idx;

  assign cnt_idx = cnt[IDX_W-1:0];

  // Track the position of the running extremum; earliest wins on a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx <= '0;
      out_idx  <= '0;
    end else if (clr) begin
      best_idx <= '0;
      out_idx  <= '0;
    end else if (in_valid && in_ready) begin
      if (state == IDLE) begin
        best_idx <= '0;
        out_idx  <= '0;
      end else if (take_new) begin
        best_idx <= cnt_idx;
        if (cnt == LAST_CNT) out_idx <= cnt_idx;
      end else if (cnt == LAST_CNT) begin
        out_idx <= best_idx;
      end
    end
  end
`else
  logic unused_take_new;
  assign unused_take_new = take_new;
`endif

  // Frame FSM with registered result outputs; clr overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      frame_mode <= MODE_MAX;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= MODE_MAX;
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc        <= in_data;
            frame_mode <= mode;
            cnt        <= CNT_W'(1);
            if (FRAME_LEN == 1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_mode  <= mode;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= sel_val;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= sel_val;
              out_mode  <= frame_mode;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : stream_extremum
`default_nettype wire

// File: tb/tb_stream_extremum.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_extremum
// Purpose  : Directed self-checking bench for stream_extremum (FRAME_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_extremum;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       mode;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_mode;
`ifdef STREAM_EXTREMUM_INDEX_EN
  logic [1:0] out_idx;
`endif

  int checks;
  int failures;

  stream_extremum #(
    .DATA_W    (8),
    .FRAME_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef STREAM_EXTREMUM_INDEX_EN
    .out_idx   (out_idx),
`endif
    .out_mode  (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for exactly one edge, then sample 1 time unit later
  task automatic feed(input logic [7:0] d, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    mode      = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // ---- reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_mode",  32'(out_mode),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- max frame 3,200,17,200 with backpressure
    feed(8'd3,   1'b0);
    feed(8'd200, 1'b0);
    feed(8'd17,  1'b0);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    feed(8'd200, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data",  32'(out_data),  32'd200);
    chk("t1_out_mode",  32'(out_mode),  32'd0);
`ifdef STREAM_EXTREMUM_INDEX_EN
    chk("t1_out_idx",   32'(out_idx),   32'd1);
`endif
    in_valid = 1'b1;
    in_data  = 8'd250;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_out_data", 32'(out_data),  32'd200);
      chk("bp_valid",    32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_hs_valid_low", 32'(out_valid), 32'd0);
    chk("bp_hs_in_ready",  32'(in_ready),  32'd1);
    // 250 was offered at the handshake edge and must not be in this frame
    feed(8'd5, 1'b0);
    feed(8'd6, 1'b0);
    feed(8'd7, 1'b0);
    feed(8'd8, 1'b0);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data",  32'(out_data),  32'd8);
    drain();

    // ---- min frame with mode toggled after first sample
    feed(8'd255, 1'b1);
    feed(8'd0,   1'b0);
    feed(8'd9,   1'b0);
    feed(8'd0,   1'b0);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_data",  32'(out_data),  32'd0);
    chk("t2_out_mode",  32'(out_mode),  32'd1);
`ifdef STREAM_EXTREMUM_INDEX_EN
    chk("t2_out_idx",   32'(out_idx),   32'd1);
`endif
    drain();

    // ---- gaps: valid pattern 1,0,0,1,0,1,1 with samples 10,40,5,30
    feed(8'd10, 1'b0);
    idle_cycle();
    idle_cycle();
    feed(8'd40, 1'b0);
    idle_cycle();
    feed(8'd5, 1'b0);
    chk("gap_no_early_valid", 32'(out_valid), 32'd0);
    feed(8'd30, 1'b0);
    chk("gap_out_valid", 32'(out_valid), 32'd1);
    chk("gap_out_data",  32'(out_data),  32'd40);
`ifdef STREAM_EXTREMUM_INDEX_EN
    chk("gap_out_idx",   32'(out_idx),   32'd1);
`endif
    drain();

    // ---- clr after two samples, then a clean min frame 1,2,3,4
    feed(8'd100, 1'b1);
    feed(8'd50,  1'b1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd0;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready",  32'(in_ready),  32'd1);
    feed(8'd1, 1'b1);
    feed(8'd2, 1'b1);
    chk("clr_no_aborted_result", 32'(out_valid), 32'd0);
    feed(8'd3, 1'b1);
    chk("clr_no_early_valid", 32'(out_valid), 32'd0);
    feed(8'd4, 1'b1);
    chk("clr_out_valid_new", 32'(out_valid), 32'd1);
    chk("clr_out_data",      32'(out_data),  32'd1);
    chk("clr_out_mode",      32'(out_mode),  32'd1);
`ifdef STREAM_EXTREMUM_INDEX_EN
    chk("clr_out_idx",       32'(out_idx),   32'd0);
`endif
    drain();

    // ---- async reset mid-ACCUM
    feed(8'd9, 1'b0);
    feed(8'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_out_valid", 32'(out_valid), 32'd0);
    chk("ra_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    feed(8'd1, 1'b0);
    feed(8'd2, 1'b0);
    feed(8'd3, 1'b0);
    chk("ra_needs_full_frame", 32'(out_valid), 32'd0);
    feed(8'd4, 1'b0);
    chk("ra_out_valid_new", 32'(out_valid), 32'd1);
    chk("ra_out_data",      32'(out_data),  32'd4);

    // ---- async reset while in HOLD
    #2;
    rst_n = 1'b0;
    #1;
    chk("rh_out_valid", 32'(out_valid), 32'd0);
    chk("rh_out_data",  32'(out_data),  32'd0);
    chk("rh_out_mode",  32'(out_mode),  32'd0);
    chk("rh_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    feed(8'd7, 1'b1);
    feed(8'd1, 1'b1);
    feed(8'd2, 1'b1);
    chk("rh_needs_full_frame", 32'(out_valid), 32'd0);
    feed(8'd3, 1'b1);
    chk("rh_out_valid_new", 32'(out_valid), 32'd1);
    chk("rh_out_data",      32'(out_data),  32'd1);
    chk("rh_out_mode",      32'(out_mode),  32'd1);
`ifdef STREAM_EXTREMUM_INDEX_EN
    chk("rh_out_idx",       32'(out_idx),   32'd1);
`endif
    drain();
    chk("end_out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stream_extremum
`default_nettype wire

// File: doc/stream_extremum.md
Name: stream_extremum

Overview:
- Sequential, streaming counterpart of the team's combinational max/min comparator.
- Consumes a valid/ready stream of unsigned samples and reduces each frame of FRAME_LEN samples to a single extremum: maximum when mode=0, minimum when mode=1.
- Returns the result on a valid/ready output port.
- Sits downstream of sample sources (ADC capture, counters) and feeds display or threshold logic.

Parameters:
- DATA_W, 8: sample and result width, unsigned.
- FRAME_LEN, 4: samples per frame. Legal range is 1..256.
- CNT_W, $clog2(FRAME_LEN+1): width of the sample counter (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous frame abort. Priority over all other inputs.
- mode  in  1  0 = max, 1 = min. Sampled only on the first accepted sample of a frame.
- in_data  in  DATA_W  sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  DATA_W  frame extremum.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_mode  out  1  mode that was used for the presented result.

Behaviour:
- Reset (rst_n low, async):
  - State returns to IDLE; counter=0; acc=0.
  - out_valid=0, out_data=0, out_mode=0.
  - in_ready is combinational and equals (state!=HOLD). It therefore reads 1 during reset, but no sample is accepted while rst_n is low.
- Handshakes:
  - A sample is accepted on a rising edge when in_valid && in_ready.
  - A result is accepted on a rising edge when out_valid && out_ready.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, on accept:
  - acc <= in_data; frame_mode <= mode; cnt <= 1.
  - Next state is ACCUM, or HOLD directly if FRAME_LEN==1.
- ACCUM, on accept:
  - acc <= (frame_mode==0) ? max(acc,in_data) : min(acc,in_data); cnt <= cnt+1.
  - When cnt+1==FRAME_LEN, go to HOLD.
  - Comparison is unsigned DATA_W wide.
  - On a tie, acc is unchanged.
  - Changes on mode mid-frame are ignored.
- HOLD:
  - out_valid=1; out_data=acc and out_mode=frame_mode are registered and stable until the output handshake; in_ready=0.
  - On output handshake: out_valid <= 0, state <= IDLE, cnt <= 0. in_ready returns to 1 in the following cycle, so no sample is taken in the handshake cycle.
- Latency: the last sample accepted at edge t gives out_valid=1 after edge t, i.e. visible in cycle t+1.
- Back-to-back throughput: FRAME_LEN+1 cycles per frame when out_ready is held at 1.
- in_valid low in ACCUM: hold state, with no change to acc or cnt.
- clr=1 at an edge: state <= IDLE, cnt <= 0, out_valid <= 0. Any partial frame or pending result is discarded, and a sample presented in the same cycle is not accepted.
- Counter never wraps: maximum value is FRAME_LEN, and it resets on frame completion.

Optional Feature:
- Macro STREAM_EXTREMUM_INDEX_EN.
- Defined:
  - Adds output port out_idx, width $clog2(FRAME_LEN) (minimum 1), holding the 0-based position in the frame of the extremum.
  - On a tie, the earliest position is kept.
  - out_idx is valid with out_valid, resets to 0, and is cleared by clr.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state enum (IDLE/ACCUM/HOLD), mode encoding constants MODE_MAX=1'b0 and MODE_MIN=1'b1.
- One sub-module: extremum_sel, a combinational 2-input select of max or min (keep-current on tie). It produces the next acc value and a "take new" flag used by the index logic.

Test Plan:
- FRAME_LEN=4, mode=0, in_valid continuous, samples 3, 200, 17, 200 -> out_data=200, out_mode=0, out_valid rises one cycle after the 4th accept; with STREAM_EXTREMUM_INDEX_EN, out_idx=1.
- mode=1, samples 255, 0, 9, 0 with mode toggled to 0 after the first sample -> out_data=0, out_mode=1 (mode latched); with STREAM_EXTREMUM_INDEX_EN, out_idx=1.
- Output backpressure: out_ready=0 for 5 cycles after result, in_valid held high -> in_ready=0 and out_data stable throughout; after out_ready=1, the next frame starts one cycle after the handshake.
- Gaps: in_valid toggling 1,0,0,1,0,1,1 with samples 10, 40, 5, 30 -> out_data=40; cnt and acc are unaffected during gaps.
- clr asserted after 2 of 4 samples, then a new frame 1, 2, 3, 4 with mode=1 -> single result out_data=1; no result is emitted for the aborted frame.
- rst_n pulsed low asynchronously mid-ACCUM and while in HOLD -> out_valid=0 and out_data=0 immediately; after release in_ready=1 and a full new frame of 4 is required.
